cpu_ctrl_fsm: RTL

Moore-style controller that sequences the simple RISC datapath. It handles one instruction at a time: MOV imm, MOV reg, ADD, CMP, AND and MVN. It sits inside the cpu top, between the instruction register/decoder and the datapath (register file, A/B/C registers, ALU, status register). It starts work on `s`, drives every datapath load/select/write strobe, and reports idle on `w`.

---
 rtl/cpu_ctrl_pkg.sv | 52 +++++
 rtl/cpu_ctrl_fsm.sv | 110 +++++++++++
 2 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the RISC datapath controller.
//   state_t      - 3-bit controller state encoding (also exported on state_o)
//   OP_* / ALU_* / MOV_* - instruction field codes for IR[15:13] / IR[12:11]
//   NSEL_*       - one-hot register-file address selects
//   VSEL_*       - writeback mux selects
//   decode_next  - state following DECODE for a given {opcode, op}
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_ALU       = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_ZERO  = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // S_WAIT doubles as "unsupported instruction".
    function automatic state_t decode_next(input logic [2:0] opcode, input logic [1:0] op);
        state_t nxt;
        nxt = S_WAIT;
        if (opcode == OP_MOV && op == MOV_IMM)      nxt = S_WRITE_IMM;
        else if (opcode == OP_MOV && op == MOV_REG) nxt = S_GET_B;
        else if (opcode == OP_ALU) begin
            if (op == ALU_MVN) nxt = S_GET_B;   // single-operand: no Rn fetch
            else               nxt = S_GET_A;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: Moore controller sequencing one instruction at a time
// through the register file / A,B,C registers / ALU / status datapath.
//   clk, reset      - rising-edge clock, async active-high reset to WAIT
//   s               - start request, only looked at in WAIT
//   opcode, op      - decoded IR fields, held stable by the caller while busy
//   w               - idle/ready
//   nsel, vsel      - register address select (one-hot) and writeback mux
//   loada/b/c, loads, write, asel, bsel - datapath strobes
//   illegal         - registered one-cycle pulse on an unsupported instruction
//   state_o         - current state for debug
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       illegal,
    output logic [2:0] state_o
);

    state_t state, state_nxt;
    logic   illegal_nxt;
    logic   is_cmp, zero_a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_WAIT;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            illegal <= illegal_nxt;
        end
    end

    // ALU-stage qualifiers read the live IR fields; the caller keeps them stable.
    assign is_cmp = (opcode == OP_ALU) && (op == ALU_CMP);
    assign zero_a = ((opcode == OP_MOV) && (op == MOV_REG)) ||
                    ((opcode == OP_ALU) && (op == ALU_MVN));

    always_comb begin
        state_nxt   = state;
        illegal_nxt = 1'b0;
        w           = 1'b0;
        nsel        = NSEL_NONE;
        vsel        = VSEL_C;
        loada       = 1'b0;
        loadb       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        write       = 1'b0;
        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt   = decode_next(opcode, op);
                illegal_nxt = ILLEGAL_TRAP && (state_nxt == S_WAIT);
            end
            S_WRITE_IMM: begin
                nsel      = NSEL_RN;
                vsel      = VSEL_IMM;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_GET_A: begin
                nsel      = NSEL_RN;
                loada     = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                nsel      = NSEL_RM;
                loadb     = 1'b1;
                state_nxt = S_ALU;
            end
            S_ALU: begin
                loadc     = 1'b1;
                asel      = zero_a;
                loads     = is_cmp;
                state_nxt = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                nsel      = NSEL_RD;
                vsel      = VSEL_C;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    assign state_o = state;

endmodule
